// File: rtl/conv_pkg.sv
// Shared widths, limits and FSM state encoding for the convolution engine.
package conv_pkg;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int ACC_W   = 2*DATA_W + ADDR_W;
  localparam int MAX_LEN = 32;

  typedef enum logic [2:0] {IDLE, SETUP, MAC, DRAIN, WRITE, DONE} convState_e;
endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate unit: unsigned sample product folded into a wide accumulator.
module conv_mac
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [2*DATA_W-1:0] product;

  assign product = a * b;

  // The accumulator is sized so that 32 full-scale products never overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(product);
    end
  end
endmodule

// File: rtl/conv_core_engine.sv
// Convolution job sequencer: walks every output index, streams X/Y taps into
// the MAC and writes each finished sum to Z memory.
module conv_core_engine
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   size_x,
  input  logic [ADDR_W:0]   size_y,
  output logic [ADDR_W-1:0] memx_addr,
  input  logic [DATA_W-1:0] memx_data,
  output logic [ADDR_W-1:0] memy_addr,
  input  logic [DATA_W-1:0] memy_data,
  output logic [ADDR_W:0]   memz_addr,
  output logic [ACC_W-1:0]  memz_data,
  output logic              memz_we,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W:0]   MAX_SIZE = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]   ONE_I    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W+1:0] TWO_W    = (ADDR_W+2)'(2);

  convState_e        state, nextState;
  logic [ADDR_W:0]   sizeX, sizeY, iCnt;
  logic [ADDR_W-1:0] kLo, kHi, addrX, addrY;
  logic [ADDR_W-1:0] kLoNext, kHiNext;
  logic [ADDR_W+1:0] lastI;
  logic              sizeBad, lastTap, lastOutput, errReg;
  logic              macClear, macEnable;
  logic [ACC_W-1:0]  acc;

  assign sizeBad = (size_x == '0) || (size_x > MAX_SIZE) ||
                   (size_y == '0) || (size_y > MAX_SIZE);
  assign lastI      = {1'b0, sizeX} + {1'b0, sizeY} - TWO_W;
  assign lastOutput = ({1'b0, iCnt} == lastI);
  assign lastTap    = (addrX == kHi);

  // Valid tap window for output i: k_lo = max(0, i-SY+1), k_hi = min(i, SX-1).
  always_comb begin
    kLoNext = '0;
    kHiNext = ADDR_W'(sizeX - ONE_I);
    if (iCnt >= sizeY) begin
      kLoNext = ADDR_W'(iCnt - sizeY + ONE_I);
    end
    if (iCnt < sizeX) begin
      kHiNext = ADDR_W'(iCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    memz_we   = 1'b0;
    macClear  = 1'b0;
    macEnable = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = sizeBad ? DONE : SETUP;
        end
      end
      SETUP: begin
        busy      = 1'b1;
        macClear  = 1'b1;
        nextState = MAC;
      end
      MAC: begin
        // Read data lags the address by a cycle, so the first tap has nothing to add yet.
        busy      = 1'b1;
        macEnable = (addrX != kLo);
        if (lastTap) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        macEnable = 1'b1;
        nextState = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        memz_we   = 1'b1;
        nextState = lastOutput ? DONE : SETUP;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sizeX  <= '0;
      sizeY  <= '0;
      iCnt   <= '0;
      kLo    <= '0;
      kHi    <= '0;
      addrX  <= '0;
      addrY  <= '0;
      errReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sizeX  <= size_x;
            sizeY  <= size_y;
            errReg <= sizeBad;
            iCnt   <= '0;
          end
        end
        SETUP: begin
          kLo   <= kLoNext;
          kHi   <= kHiNext;
          addrX <= kLoNext;
          addrY <= ADDR_W'(iCnt - {1'b0, kLoNext});
        end
        MAC: begin
          if (!lastTap) begin
            addrX <= addrX + ONE_A;
            addrY <= addrY - ONE_A;
          end
        end
        WRITE: begin
          if (!lastOutput) begin
            iCnt <= iCnt + ONE_I;
          end
        end
        default: ;
      endcase
    end
  end

  conv_mac macUnit (
    .clk    (clk),
    .rst    (rst),
    .clear  (macClear),
    .enable (macEnable),
    .a      (memx_data),
    .b      (memy_data),
    .acc    (acc)
  );

  assign memx_addr = addrX;
  assign memy_addr = addrY;
  assign memz_addr = iCnt;
  assign memz_data = acc;
  assign err       = errReg;
endmodule

// File: tb/tb_conv_core_engine.sv
// Self-checking bench for conv_core_engine: directed corner jobs plus random
// jobs, compared against a direct convolution sum and cycle-count model.
module tb_conv_core_engine;
  logic        clk, rst, start;
  logic [5:0]  size_x, size_y;
  logic [4:0]  memx_addr, memy_addr;
  logic [7:0]  memx_data, memy_data;
  logic [5:0]  memz_addr;
  logic [20:0] memz_data;
  logic        memz_we, busy, done, err;

  logic [7:0]  memX [32];
  logic [7:0]  memY [32];
  int          zAddrQ[$];
  longint      zDataQ[$];
  int          vectorCount = 0;
  int          missCount = 0;
  int          busyCnt, jobCycles;

  conv_core_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .size_x    (size_x),
    .size_y    (size_y),
    .memx_addr (memx_addr),
    .memx_data (memx_data),
    .memy_addr (memy_addr),
    .memy_data (memy_data),
    .memz_addr (memz_addr),
    .memz_data (memz_data),
    .memz_we   (memz_we),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // X/Y memories with one-cycle synchronous read.
  always @(posedge clk) begin
    memx_data <= memX[memx_addr];
    memy_data <= memY[memy_addr];
  end

  always @(negedge clk) begin
    if (memz_we === 1'b1) begin
      zAddrQ.push_back(int'(memz_addr));
      zDataQ.push_back(longint'(memz_data));
    end
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int tCount(input int i, input int sx, input int sy);
    int n = 0;
    for (int k = 0; k < sx; k++) if (i - k >= 0 && i - k < sy) n++;
    return n;
  endfunction

  function automatic longint expZ(input int i, input int sx, input int sy);
    longint s = 0;
    for (int k = 0; k < sx; k++)
      if (i - k >= 0 && i - k < sy) s += longint'(memX[k]) * longint'(memY[i-k]);
    return s;
  endfunction

  function automatic int setupCycle(input int i, input int sx, input int sy);
    int c = 2;
    for (int j = 0; j < i; j++) c += tCount(j, sx, sy) + 3;
    return c;
  endfunction

  function automatic longint zAt(input int j);
    return (j < zDataQ.size()) ? zDataQ[j] : -1;
  endfunction

  task automatic fillRandom();
    for (int k = 0; k < 32; k++) begin
      memX[k] = 8'($urandom_range(0, 255));
      memY[k] = 8'($urandom_range(0, 255));
    end
  endtask

  // Cycle 1 is the cycle start is high; done is expected in cycle sum(T_i+3)+2.
  task automatic applyStimulus(input string name, input int sx, input int sy,
                               input int repulseAt, input int newSx, input int newSy,
                               input int rstAt);
    bit legal;
    int cyc, nOut, limit;
    legal = (sx >= 1 && sx <= 32 && sy >= 1 && sy <= 32);
    nOut  = legal ? sx + sy - 1 : 0;
    limit = 5000;
    zAddrQ.delete();
    zDataQ.delete();
    @(negedge clk);
    size_x = 6'(sx);
    size_y = 6'(sy);
    start  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cyc     = 2;
    busyCnt = 0;
    forever begin
      if (done === 1'b1 || cyc >= limit) break;
      if (busy === 1'b1) busyCnt++;
      if (rstAt > 0 && cyc == rstAt) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput({name, ".busyAfterRst"}, longint'(busy), 0);
        checkOutput({name, ".doneAfterRst"}, longint'(done), 0);
        checkOutput({name, ".weAfterRst"}, longint'(memz_we), 0);
        checkOutput({name, ".xAddrAfterRst"}, longint'(memx_addr), 0);
        return;
      end
      if (repulseAt > 0 && cyc == repulseAt) begin
        start  = 1'b1;
        size_x = 6'(newSx);
        size_y = 6'(newSy);
      end else if (repulseAt > 0 && cyc == repulseAt + 1) begin
        start  = 1'b0;
        size_x = 6'(sx);
        size_y = 6'(sy);
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    jobCycles = cyc;
    checkOutput({name, ".doneSeen"}, longint'(done), 1);
    checkOutput({name, ".cycles"}, jobCycles, legal ? setupCycle(nOut, sx, sy) : 2);
    checkOutput({name, ".busyCycles"}, busyCnt, legal ? setupCycle(nOut, sx, sy) - 2 : 0);
    checkOutput({name, ".busyAtDone"}, longint'(busy), 0);
    checkOutput({name, ".err"}, longint'(err), legal ? 0 : 1);
    checkOutput({name, ".writes"}, zAddrQ.size(), nOut);
    for (int j = 0; j < zAddrQ.size() && j < 64; j++) begin
      checkOutput($sformatf("%s.zAddr%0d", name, j), zAddrQ[j], j);
      checkOutput($sformatf("%s.z%0d", name, j), zDataQ[j], expZ(j, sx, sy));
    end
    @(negedge clk);
    checkOutput({name, ".donePulse"}, longint'(done), 0);
    checkOutput({name, ".errHeld"}, longint'(err), legal ? 0 : 1);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    size_x = '0;
    size_y = '0;
    for (int k = 0; k < 32; k++) begin
      memX[k] = '0;
      memY[k] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", longint'(busy), 0);
    checkOutput("reset.done", longint'(done), 0);
    checkOutput("reset.err", longint'(err), 0);
    checkOutput("reset.we", longint'(memz_we), 0);
    checkOutput("reset.xAddr", longint'(memx_addr), 0);
    checkOutput("reset.yAddr", longint'(memy_addr), 0);
    checkOutput("reset.zAddr", longint'(memz_addr), 0);
    rst = 1'b0;

    memX[0] = 8'd1; memX[1] = 8'd2; memX[2] = 8'd3;
    memY[0] = 8'd1; memY[1] = 8'd1;
    applyStimulus("small", 3, 2, 0, 0, 0, 0);
    checkOutput("small.z0", zAt(0), 1);
    checkOutput("small.z1", zAt(1), 3);
    checkOutput("small.z2", zAt(2), 5);
    checkOutput("small.z3", zAt(3), 3);

    memX[0] = 8'd255; memY[0] = 8'd255;
    applyStimulus("single", 1, 1, 0, 0, 0, 0);
    checkOutput("single.z0", zAt(0), 65025);
    checkOutput("single.busyCount", busyCnt, 4);

    for (int k = 0; k < 32; k++) begin
      memX[k] = 8'd255;
      memY[k] = 8'd255;
    end
    applyStimulus("full", 32, 32, 0, 0, 0, 0);
    checkOutput("full.z31", zAt(31), 2080800);
    checkOutput("full.z62", zAt(62), 65025);

    applyStimulus("sizeXZero", 0, 5, 0, 0, 0, 0);
    applyStimulus("sizeY33", 4, 33, 0, 0, 0, 0);

    fillRandom();
    applyStimulus("restartIgnored", 4, 3, 4, 2, 2, 0);

    fillRandom();
    applyStimulus("midReset", 5, 4, 0, 0, 0, setupCycle(2, 5, 4) + 2);
    checkOutput("midReset.partialWrites", zAddrQ.size(), 2);
    applyStimulus("afterReset", 5, 4, 0, 0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      fillRandom();
      applyStimulus($sformatf("rand%0d", n), $urandom_range(1, 32), $urandom_range(1, 32), 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
